// File: rtl/edge_pulse_generator.sv
// Level-to-pulse converter: optional input synchroniser, selectable edge
// detection and a registered pulse of programmable width with optional retrigger.
module edge_pulse_generator #(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_WIDTH = 1,
    parameter int EDGE_MODE   = 0,
    parameter int RETRIGGER   = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic input_signal,
    output logic pulse
);

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_e;

    localparam int         WIDTH   = (PULSE_WIDTH < 1) ? 1 : PULSE_WIDTH;
    localparam int         CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WIDTH - 1);
    localparam edge_mode_e MODE    = edge_mode_e'(EDGE_MODE[1:0]);
    localparam bit         RETRIG  = (RETRIGGER != 0);

    logic             s;
    logic             prev;
    logic             rise;
    logic             fall;
    logic             edge_hit;
    logic [CNT_W-1:0] cnt;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] sync;

            // NOTE: non-blocking assignments let every stage sample the value its
            // predecessor held before this edge, so the chain shifts by one flop.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync <= '0;
                end else begin
                    sync[0] <= input_signal;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync[i] <= sync[i-1];
                    end
                end
            end

            assign s = sync[SYNC_STAGES-1];
        end else begin : g_bypass
            assign s = input_signal;
        end
    endgenerate

    always_comb begin
        rise     = s & ~prev;
        fall     = ~s & prev;
        edge_hit = rise;
        case (MODE)
            EDGE_FALL: edge_hit = fall;
            EDGE_BOTH: edge_hit = rise | fall;
            default:   edge_hit = rise;
        endcase
    end

    // An edge is accepted when idle, or at any time when retriggering is enabled;
    // the counter holds the number of extra high cycles still owed.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            prev <= s;
            if (edge_hit && (!pulse || RETRIG)) begin
                pulse <= 1'b1;
                cnt   <= RELOAD;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                pulse <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_edge_pulse_generator.sv
// Drives six differently-parameterised edge_pulse_generator instances with one
// shared stimulus and checks every output against a hand-derived cycle table.
module tb_edge_pulse_generator;

    localparam int NDUT  = 6;
    localparam int LAST  = 365;

    typedef struct {
        int              cyc;
        logic [NDUT-1:0] want;
        string           tag;
    } exp_t;

    logic clk;
    logic rst;
    logic din;
    logic [NDUT-1:0] pulses;

    exp_t            sb[$];
    logic [NDUT-1:0] want_tbl [0:LAST+1];
    int              cyc;
    int              checks;
    int              errors;

    // 0: defaults  1: falling  2: both  3: width 4  4: width 4 retrigger  5: no sync
    edge_pulse_generator #(.SYNC_STAGES(2), .PULSE_WIDTH(1), .EDGE_MODE(0), .RETRIGGER(0))
        u_rise (.clk(clk), .rst(rst), .input_signal(din), .pulse(pulses[0]));
    edge_pulse_generator #(.SYNC_STAGES(2), .PULSE_WIDTH(1), .EDGE_MODE(1), .RETRIGGER(0))
        u_fall (.clk(clk), .rst(rst), .input_signal(din), .pulse(pulses[1]));
    edge_pulse_generator #(.SYNC_STAGES(2), .PULSE_WIDTH(1), .EDGE_MODE(2), .RETRIGGER(0))
        u_both (.clk(clk), .rst(rst), .input_signal(din), .pulse(pulses[2]));
    edge_pulse_generator #(.SYNC_STAGES(2), .PULSE_WIDTH(4), .EDGE_MODE(0), .RETRIGGER(0))
        u_pw4 (.clk(clk), .rst(rst), .input_signal(din), .pulse(pulses[3]));
    edge_pulse_generator #(.SYNC_STAGES(2), .PULSE_WIDTH(4), .EDGE_MODE(0), .RETRIGGER(1))
        u_pw4_rt (.clk(clk), .rst(rst), .input_signal(din), .pulse(pulses[4]));
    edge_pulse_generator #(.SYNC_STAGES(0), .PULSE_WIDTH(1), .EDGE_MODE(0), .RETRIGGER(0))
        u_nosync (.clk(clk), .rst(rst), .input_signal(din), .pulse(pulses[5]));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic window(input int idx, input int lo, input int hi);
        for (int c = lo; c <= hi; c++) begin
            want_tbl[c][idx] = 1'b1;
        end
    endtask

    // Inputs are applied for the next rising edge; its expected outputs are queued
    // now and checked at the following falling edge.
    task automatic step(input logic d, input logic r, input string tag);
        exp_t e;
        din = d;
        rst = r;
        e.cyc  = cyc + 1;
        e.want = want_tbl[cyc + 1];
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        e = sb.pop_front();
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            assert (pulses[i] === e.want[i])
            else begin
                errors++;
                $error("FAIL %s dut%0d cycle %0d: pulse=%b expected=%b",
                       e.tag, i, e.cyc, pulses[i], e.want[i]);
            end
        end
    endtask

    task automatic run(input int n, input logic d, input logic r, input string tag);
        for (int k = 0; k < n; k++) begin
            step(d, r, tag);
        end
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        din    = 1'b0;
        rst    = 1'b1;
        for (int c = 0; c <= LAST + 1; c++) begin
            want_tbl[c] = '0;
        end

        // Rising edge sampled at 56, falling at 306
        window(0, 58, 58);   window(2, 58, 58);   window(3, 58, 61);
        window(4, 58, 61);   window(5, 56, 56);
        window(1, 308, 308); window(2, 308, 308);
        // Samples 321=1, 322=0, 323=1: second rise two cycles into the pulse
        window(0, 323, 323); window(0, 325, 325);
        window(1, 324, 324);
        window(2, 323, 323); window(2, 325, 325);
        window(3, 323, 326);
        window(4, 323, 328);
        window(5, 321, 321); window(5, 323, 323);
        // Fall sampled at 341, rise at 345, reset at 348 with input still high
        window(1, 343, 343); window(2, 343, 343);
        window(0, 347, 347); window(2, 347, 347); window(3, 347, 347); window(4, 347, 347);
        window(5, 345, 345);
        window(0, 351, 351); window(2, 351, 351); window(3, 351, 354); window(4, 351, 354);
        window(5, 349, 349);

        run(5,   1'b0, 1'b1, "reset");        // cycles 1..5
        run(50,  1'b0, 1'b0, "idle");         // 6..55
        run(250, 1'b1, 1'b0, "rise_hold");    // 56..305
        run(15,  1'b0, 1'b0, "fall");         // 306..320
        step(1'b1, 1'b0, "retrig");           // 321
        step(1'b0, 1'b0, "retrig");           // 322
        run(18,  1'b1, 1'b0, "retrig");       // 323..340
        run(4,   1'b0, 1'b0, "pre_rst");      // 341..344
        run(3,   1'b1, 1'b0, "pre_rst");      // 345..347
        step(1'b1, 1'b1, "rst_mid");          // 348
        run(LAST - 348, 1'b1, 1'b0, "post_rst"); // 349..365

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
